// File: rtl/adder_2_inputs_accumulator.sv
// adder_2_inputs_accumulator
// Accepts {carry_out, result} beats from the upstream 2-input adder and sums
// BEATS of them into a saturating ACC_WIDTH accumulator. It also counts the
// beats that carried out. The finished frame is held on a registered
// valid/ready port until downstream takes it.
//
// state | meaning
// IDLE  | out of reset, waiting one edge before accepting beats
// ACCUM | accepting beats, in_ready=1
// HOLD  | frame complete, out_valid=1, beats refused until out_ready

module adder_2_inputs_accumulator #(
  parameter int WIDTH     = 4,
  parameter int BEATS     = 4,
  parameter int ACC_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             result,
  input  logic                         carry_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ACC_WIDTH-1:0]         sum_out,
  output logic [$clog2(BEATS+1)-1:0]   carry_count,
  output logic                         overflow
);

  localparam int CW = $clog2(BEATS+1);
  localparam int SW = ACC_WIDTH + 1;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {ACC_WIDTH{1'b1}};
  localparam logic [CW-1:0]        LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                state_q;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [CW-1:0]         beat_q;
  logic [CW-1:0]         carry_q;
  logic                  ovf_q;
  logic                  in_ready_q;
  logic                  out_valid_q;

  logic                  accept;
  logic [SW-1:0]         acc_sum_d;
  logic                  sat_d;
  logic [ACC_WIDTH-1:0]  acc_d;

  // Beat acceptance and the one-bit-wider add with clamp; the operand is only
  // used when a beat is accepted, so idle-cycle X on result never reaches state.
  always_comb begin
    accept    = in_valid && in_ready_q && (state_q == ACCUM);
    acc_sum_d = {1'b0, acc_q} + SW'({carry_out, result});
    sat_d     = acc_sum_d[ACC_WIDTH];
    acc_d     = sat_d ? ACC_MAX : acc_sum_d[ACC_WIDTH-1:0];
  end

  // Frame FSM with all outputs registered; clear beats every event but reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      beat_q      <= '0;
      carry_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (clear) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      beat_q      <= '0;
      carry_q     <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= ACCUM;
          in_ready_q <= 1'b1;
        end
        ACCUM: begin
          if (accept) begin
            acc_q  <= acc_d;
            ovf_q  <= ovf_q | sat_d;
            beat_q <= beat_q + CW'(1);
            if (carry_out) begin
              carry_q <= carry_q + CW'(1);
            end
            if (beat_q == LAST_BEAT) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          // Totals stay frozen until consumed; the consuming edge starts
          // a fresh frame and accepts no beat of its own.
          if (out_ready) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            beat_q      <= '0;
            carry_q     <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign sum_out     = acc_q;
  assign carry_count = carry_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_adder_2_inputs_accumulator.sv
// Bench for adder_2_inputs_accumulator: two instances that share stimulus
// (ACC_WIDTH 8 and 6) checked every cycle against a frame-level model.

module tb_adder_2_inputs_accumulator;

  localparam int WIDTH = 4;
  localparam int BEATS = 4;
  localparam int CW    = $clog2(BEATS+1);

  logic             clk;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             out_ready;

  logic             a_in_ready, a_out_valid, a_overflow;
  logic [7:0]       a_sum;
  logic [CW-1:0]    a_cc;
  logic             b_in_ready, b_out_valid, b_overflow;
  logic [5:0]       b_sum;
  logic [CW-1:0]    b_cc;

  int n_tests = 0;
  int n_fail  = 0;

  // frame-level reference: running totals of accepted beats
  bit m_started, m_ready, m_valid;
  int m_total, m_carry, m_beats;

  adder_2_inputs_accumulator #(.WIDTH(WIDTH), .BEATS(BEATS), .ACC_WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(a_in_ready), .result(result), .carry_out(carry_out),
    .out_valid(a_out_valid), .out_ready(out_ready), .sum_out(a_sum),
    .carry_count(a_cc), .overflow(a_overflow)
  );

  adder_2_inputs_accumulator #(.WIDTH(WIDTH), .BEATS(BEATS), .ACC_WIDTH(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid),
    .in_ready(b_in_ready), .result(result), .carry_out(carry_out),
    .out_valid(b_out_valid), .out_ready(out_ready), .sum_out(b_sum),
    .carry_count(b_cc), .overflow(b_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int total, input int maxv);
    return (total > maxv) ? maxv : total;
  endfunction

  task automatic check_all();
    check("in_ready8",  32'(a_in_ready),  32'(m_ready));
    check("in_ready6",  32'(b_in_ready),  32'(m_ready));
    check("out_valid8", 32'(a_out_valid), 32'(m_valid));
    check("out_valid6", 32'(b_out_valid), 32'(m_valid));
    check("sum8",       32'(a_sum),       32'(sat(m_total, 255)));
    check("sum6",       32'(b_sum),       32'(sat(m_total, 63)));
    check("ccount8",    32'(a_cc),        32'(m_carry));
    check("ccount6",    32'(b_cc),        32'(m_carry));
    check("ovf8",       32'(a_overflow),  32'(m_total > 255));
    check("ovf6",       32'(b_overflow),  32'(m_total > 63));
  endtask

  task automatic frame_reset();
    m_total = 0;
    m_carry = 0;
    m_beats = 0;
  endtask

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic cyc(input bit v, input bit [WIDTH-1:0] r, input bit c,
                     input bit ordy, input bit clr);
    bit acc, fin;
    in_valid  = v;
    result    = v ? r : 'x;
    carry_out = v ? c : 1'bx;
    out_ready = ordy;
    clear     = clr;
    acc = v && m_ready && !clr;
    fin = m_valid && ordy && !clr;
    @(posedge clk);
    #1;
    if (clr || !m_started) begin
      frame_reset();
      m_started = 1;
      m_ready   = 1;
      m_valid   = 0;
    end else if (fin) begin
      frame_reset();
      m_ready = 1;
      m_valid = 0;
    end else if (acc) begin
      m_total += int'(r) + (c ? 16 : 0);
      m_carry += int'(c);
      m_beats++;
      if (m_beats == BEATS) begin
        m_valid = 1;
        m_ready = 0;
      end
    end
    check_all();
  endtask

  // Asynchronous reset taken mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    #2;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    m_started = 0;
    m_ready   = 0;
    m_valid   = 0;
    frame_reset();
    #1;
    check_all();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; result = '0;
    carry_out = 1'b0; out_ready = 1'b0;
    m_started = 0; m_ready = 0; m_valid = 0;
    frame_reset();
    @(posedge clk);
    #1;

    // start-up: in_ready one edge after release
    do_reset();
    check("startup_ready_low", 32'(a_in_ready), 32'd0);
    cyc(0, 0, 0, 0, 0);
    check("startup_ready_high", 32'(a_in_ready), 32'd1);

    // basic frame with a two-cycle gap
    cyc(1, 7, 0, 0, 0); cyc(1, 7, 0, 0, 0);
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    cyc(1, 7, 0, 0, 0); cyc(1, 7, 0, 0, 0);
    check("basic_valid", 32'(a_out_valid), 32'd1);
    check("basic_sum",   32'(a_sum),       32'd28);
    check("basic_cc",    32'(a_cc),        32'd0);
    cyc(0, 0, 0, 1, 0);

    // carry beats: 120 in 8 bits, saturates at 63 in 6 bits
    cyc(1, 14, 1, 0, 0); cyc(1, 14, 1, 0, 0);
    check("sat_not_yet", 32'(b_overflow), 32'd0);
    cyc(1, 14, 1, 0, 0);
    check("sat_third_beat", 32'(b_overflow), 32'd1);
    cyc(1, 14, 1, 0, 0);
    check("carry_sum8", 32'(a_sum), 32'd120);
    check("carry_cc8",  32'(a_cc),  32'd4);
    check("carry_ovf8", 32'(a_overflow), 32'd0);
    check("sat_sum6",   32'(b_sum), 32'd63);
    check("sat_cc6",    32'(b_cc),  32'd4);

    // backpressure with in_valid held high
    repeat (5) cyc(1, 3, 0, 0, 0);
    check("bp_hold_sum", 32'(a_sum), 32'd120);
    cyc(1, 3, 0, 1, 0);
    check("bp_release_valid", 32'(a_out_valid), 32'd0);
    check("bp_release_sum",   32'(a_sum),       32'd0);

    // clear discards the coincident beat
    cyc(1, 9, 0, 0, 0); cyc(1, 9, 0, 0, 0);
    cyc(1, 9, 0, 0, 1);
    check("clear_sum", 32'(a_sum), 32'd0);
    repeat (4) cyc(1, 5, 0, 0, 0);
    check("clear_frame_sum", 32'(a_sum), 32'd20);
    check("clear_frame_valid", 32'(a_out_valid), 32'd1);

    // async reset while in HOLD
    do_reset();
    check("async_rst_valid", 32'(a_out_valid), 32'd0);
    cyc(0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
          ($urandom_range(0, 49) == 0));
      if ($urandom_range(0, 999) == 0) begin
        do_reset();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
